// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared configuration for the GEMM tile sequencer: systolic array geometry,
// GEMM register block offsets, M block size and the sequencer state encoding.
package gemm_tile_sequencer_pkg;

  localparam logic [15:0] SUPER_SYS_ROWS = 16'd16;
  localparam logic [15:0] SUPER_SYS_COLS = 16'd16;
  localparam logic [15:0] M_BLOCK        = 16'd16;

  localparam logic [31:0] OFF_A    = 32'd0;
  localparam logic [31:0] OFF_B    = 32'd4;
  localparam logic [31:0] OFF_C    = 32'd8;
  localparam logic [31:0] OFF_ASTR = 32'd12;
  localparam logic [31:0] OFF_BSTR = 32'd16;
  localparam logic [31:0] OFF_CTRL = 32'd20;
  localparam logic [31:0] OFF_DIM  = 32'd24;

  typedef enum logic [3:0] {
    IDLE, WR_ASTR, WR_BSTR, WR_AADR, WR_BADR, WR_CADR, WR_CTRL, WR_DIM,
    POLL_FULL, ADVANCE, POLL_DONE, FINISH
  } seq_state_t;

  // Tile extent along one axis: whatever remains of the dimension, capped at the block.
  function automatic logic [15:0] clamp_size(input logic [15:0] dim,
                                             input logic [15:0] pos,
                                             input logic [15:0] block);
    logic [15:0] rem;
    rem = dim - pos;
    return (rem < block) ? rem : block;
  endfunction

  // True when the tile starting at pos reaches or passes the end of the dimension.
  function automatic logic reaches_end(input logic [15:0] dim,
                                       input logic [15:0] pos,
                                       input logic [15:0] block);
    return (17'(pos) + 17'(block)) >= 17'(dim);
  endfunction

endpackage

// File: rtl/gemm_tile_walker.sv
// Tile walker: n outermost, m middle, k innermost loop counters, plus the
// clamped tile sizes and the first/last flags of the current tile.
module gemm_tile_walker
  import gemm_tile_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        step,
  input  logic [15:0] dim_m,
  input  logic [15:0] dim_k,
  input  logic [15:0] dim_n,
  output logic [15:0] m_idx,
  output logic [15:0] k_idx,
  output logic [15:0] n_idx,
  output logic [15:0] msz,
  output logic [15:0] ksz,
  output logic [15:0] nsz,
  output logic        first,
  output logic        last,
  output logic        final_tile
);

  logic k_wrap;
  logic m_wrap;
  logic n_wrap;

  assign k_wrap     = reaches_end(dim_k, k_idx, SUPER_SYS_ROWS);
  assign m_wrap     = reaches_end(dim_m, m_idx, M_BLOCK);
  assign n_wrap     = reaches_end(dim_n, n_idx, SUPER_SYS_COLS);
  assign msz        = clamp_size(dim_m, m_idx, M_BLOCK);
  assign ksz        = clamp_size(dim_k, k_idx, SUPER_SYS_ROWS);
  assign nsz        = clamp_size(dim_n, n_idx, SUPER_SYS_COLS);
  assign first      = (k_idx == 16'd0);
  assign last       = k_wrap;
  assign final_tile = k_wrap & m_wrap & n_wrap;

  // Nested counter advance: k wraps into m, m wraps into n, n wraps to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx <= '0;
      k_idx <= '0;
      n_idx <= '0;
    end else if (clear) begin
      m_idx <= '0;
      k_idx <= '0;
      n_idx <= '0;
    end else if (step) begin
      if (!k_wrap) begin
        k_idx <= k_idx + SUPER_SYS_ROWS;
      end else begin
        k_idx <= '0;
        if (!m_wrap) begin
          m_idx <= m_idx + M_BLOCK;
        end else begin
          m_idx <= '0;
          n_idx <= n_wrap ? 16'd0 : n_idx + SUPER_SYS_COLS;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer top: latches a job, programs the GEMM register block
// tile by tile over the system bus, polls for queue space and completion.
// Optional build macro GEMM_SEQ_CYCLE_CNT_EN enables the busy-cycle counter;
// without it cycle_count is tied to zero.
// Bus: system_bus_en marks a single-cycle access; rdwr=1 write, 0 read. Read
// data is sampled on the cycle after the read is issued, with the bus idle.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter logic [31:0] GEMM_BASE = 32'h9000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dim_m,
  input  logic [15:0] dim_k,
  input  logic [15:0] dim_n,
  input  logic [31:0] a_base,
  input  logic [31:0] b_base,
  input  logic [31:0] c_base,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_count,
  output logic        system_bus_en,
  output logic        system_bus_rdwr,
  output logic [31:0] system_bus_addr,
  output logic [31:0] system_bus_wr_data,
  input  logic [31:0] system_bus_rd_data,
  output seq_state_t  fsm_state
);

  seq_state_t  state_q, state_d;
  logic        poll_phase_q, poll_phase_d;
  logic [15:0] m_q, k_q, n_q;
  logic [31:0] a_q, b_q, c_q;
  logic [15:0] m_idx, k_idx, n_idx, msz, ksz, nsz;
  logic        first, last, final_tile;
  logic        accept, zero_dim, step;
  logic [31:0] a_tile, b_tile, c_tile, dim_word;
  logic        unused_rd_bits;

  assign accept         = (state_q == IDLE) && start;
  assign zero_dim       = (dim_m == 16'd0) || (dim_k == 16'd0) || (dim_n == 16'd0);
  assign busy           = (state_q != IDLE);
  assign fsm_state      = state_q;
  assign unused_rd_bits = ^system_bus_rd_data[31:1];

  assign a_tile   = a_q + 32'(m_idx) * 32'(k_q) + 32'(k_idx);
  assign b_tile   = b_q + (32'(k_idx) + 32'(ksz) - 32'd1) * 32'(n_q) + 32'(n_idx);
  assign c_tile   = c_q + 32'(m_idx) * 32'(n_q) + 32'(n_idx);
  assign dim_word = 32'(msz) | (32'(ksz) << 5) | (32'(nsz) << 10);

  gemm_tile_walker u_walker (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .step       (step),
    .dim_m      (m_q),
    .dim_k      (k_q),
    .dim_n      (n_q),
    .m_idx      (m_idx),
    .k_idx      (k_idx),
    .n_idx      (n_idx),
    .msz        (msz),
    .ksz        (ksz),
    .nsz        (nsz),
    .first      (first),
    .last       (last),
    .final_tile (final_tile)
  );

  // Job parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0; k_q <= '0; n_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0;
    end else if (accept) begin
      m_q <= dim_m; k_q <= dim_k; n_q <= dim_n;
      a_q <= a_base; b_q <= b_base; c_q <= c_base;
    end
  end

  // State register and the issue/sample phase of the polling states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      poll_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      poll_phase_q <= poll_phase_d;
    end
  end

  // Next state and bus drive; polls alternate an issue cycle and a sample cycle.
  always_comb begin
    state_d            = state_q;
    poll_phase_d       = 1'b0;
    step               = 1'b0;
    done               = 1'b0;
    system_bus_en      = 1'b0;
    system_bus_rdwr    = 1'b0;
    system_bus_addr    = 32'd0;
    system_bus_wr_data = 32'd0;
    case (state_q)
      IDLE: begin
        if (start) state_d = zero_dim ? FINISH : WR_ASTR;
      end
      WR_ASTR: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_ASTR; system_bus_wr_data = 32'(k_q);
        state_d = WR_BSTR;
      end
      WR_BSTR: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_BSTR; system_bus_wr_data = 32'(n_q);
        state_d = WR_AADR;
      end
      WR_AADR: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_A; system_bus_wr_data = a_tile;
        state_d = WR_BADR;
      end
      WR_BADR: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_B; system_bus_wr_data = b_tile;
        state_d = WR_CADR;
      end
      WR_CADR: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_C; system_bus_wr_data = c_tile;
        state_d = WR_CTRL;
      end
      WR_CTRL: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_CTRL; system_bus_wr_data = {30'd0, first, last};
        state_d = WR_DIM;
      end
      WR_DIM: begin
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = GEMM_BASE + OFF_DIM; system_bus_wr_data = dim_word;
        state_d = POLL_FULL;
      end
      POLL_FULL: begin
        if (!poll_phase_q) begin
          system_bus_en   = 1'b1;
          system_bus_addr = GEMM_BASE + OFF_A;
          poll_phase_d    = 1'b1;
        end else if (!system_bus_rd_data[0]) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        step    = 1'b1;
        state_d = final_tile ? POLL_DONE : WR_ASTR;
      end
      POLL_DONE: begin
        if (!poll_phase_q) begin
          system_bus_en   = 1'b1;
          system_bus_addr = GEMM_BASE + OFF_DIM;
          poll_phase_d    = 1'b1;
        end else if (system_bus_rd_data[0]) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GEMM_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  // Counts every busy cycle of the current job; holds once back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cycle_cnt_q <= '0;
    else if (accept) cycle_cnt_q <= '0;
    else if (busy)   cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign cycle_count = cycle_cnt_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Testbench for gemm_tile_sequencer: transaction-level job model, bus
// responder with scripted poll answers, per-cycle bus/done compare process.
module tb_gemm_tile_sequencer;
  import gemm_tile_sequencer_pkg::*;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int W = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start;
  logic [15:0] dim_m, dim_k, dim_n;
  logic [31:0] a_base, b_base, c_base;
  logic        busy, done;
  logic [31:0] cycle_count;
  logic        system_bus_en, system_bus_rdwr;
  logic [31:0] system_bus_addr, system_bus_wr_data;
  logic [31:0] system_bus_rd_data = '0;
  seq_state_t  fsm_state;

  gemm_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .cycle_count(cycle_count),
    .system_bus_en(system_bus_en), .system_bus_rdwr(system_bus_rdwr),
    .system_bus_addr(system_bus_addr), .system_bus_wr_data(system_bus_wr_data),
    .system_bus_rd_data(system_bus_rd_data), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           full_polls[$];
  int           done_polls = 0;
  int           mdl_tiles, exp_cycles;
  logic [31:0]  mdl_a[$], mdl_b[$], mdl_c[$], mdl_ctrl[$], mdl_dim[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Job model: walks tiles with plain loops and lists the exact bus traffic.
  task automatic build_model(input int mm, input int kk, input int nn,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_q.delete();
    mdl_a.delete(); mdl_b.delete(); mdl_c.delete(); mdl_ctrl.delete(); mdl_dim.delete();
    mdl_tiles  = 0;
    exp_cycles = 0;
    if (mm == 0 || kk == 0 || nn == 0) begin
      exp_cycles = 1;
      return;
    end
    for (int n = 0; n < nn; n += 16)
      for (int m = 0; m < mm; m += 16)
        for (int k = 0; k < kk; k += 16) begin
          int ns, ms, ks, fp;
          logic [31:0] av, bv, cv, ctrl, dim;
          ns   = (nn - n < 16) ? nn - n : 16;
          ms   = (mm - m < 16) ? mm - m : 16;
          ks   = (kk - k < 16) ? kk - k : 16;
          av   = a + 32'(m * kk + k);
          bv   = b + 32'((k + ks - 1) * nn + n);
          cv   = c + 32'(m * nn + n);
          ctrl = {30'd0, (k == 0), (k + 16 >= kk)};
          dim  = 32'(ms + ks * 32 + ns * 1024);
          mdl_a.push_back(av); mdl_b.push_back(bv); mdl_c.push_back(cv);
          mdl_ctrl.push_back(ctrl); mdl_dim.push_back(dim);
          exp_q.push_back({1'b1, BASE + 32'd12, 32'(kk)});
          exp_q.push_back({1'b1, BASE + 32'd16, 32'(nn)});
          exp_q.push_back({1'b1, BASE + 32'd0,  av});
          exp_q.push_back({1'b1, BASE + 32'd4,  bv});
          exp_q.push_back({1'b1, BASE + 32'd8,  cv});
          exp_q.push_back({1'b1, BASE + 32'd20, ctrl});
          exp_q.push_back({1'b1, BASE + 32'd24, dim});
          fp = (mdl_tiles < full_polls.size()) ? full_polls[mdl_tiles] : 0;
          repeat (fp + 1) exp_q.push_back({1'b0, BASE + 32'd0, 32'd0});
          exp_cycles += 7 + 2 * (fp + 1) + 1;
          mdl_tiles++;
        end
    repeat (done_polls + 1) exp_q.push_back({1'b0, BASE + 32'd24, 32'd0});
    exp_cycles += 2 * (done_polls + 1) + 1;
  endtask

  // ---------------- compare process + bus responder ----------------
  logic [W-1:0] got_op, want_op;
  int resp_tile = 0, fp_seen = 0, dp_seen = 0, fp_cur;
  int full_reads = 0, bus_ops = 0, done_count = 0, done_cyc = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      exp_q.delete();
      resp_tile = 0; fp_seen = 0; dp_seen = 0;
      prev_done = 1'b0;
    end else begin
      if (system_bus_en) begin
        bus_ops++;
        chk("busy_during_bus", busy, 1'b1);
        got_op = {system_bus_rdwr, system_bus_addr, system_bus_rdwr ? system_bus_wr_data : 32'd0};
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_bus_op: got %0h expected no bus access (t=%0t)", got_op, $time);
        end else begin
          want_op = exp_q.pop_front();
          chk("bus_op", got_op, want_op);
        end
        if (!system_bus_rdwr) begin
          if (system_bus_addr == BASE) begin
            full_reads++;
            fp_cur = (resp_tile < full_polls.size()) ? full_polls[resp_tile] : 0;
            if (fp_seen < fp_cur) begin
              system_bus_rd_data = 32'h0000_0001; fp_seen++;
            end else begin
              system_bus_rd_data = 32'hFFFF_FFFE; fp_seen = 0; resp_tile++;
            end
          end else if (dp_seen < done_polls) begin
            system_bus_rd_data = 32'hFFFF_FFFE; dp_seen++;
          end else begin
            system_bus_rd_data = 32'h0000_0003;
          end
        end
      end
      if (done) begin
        chk("done_queue_drained", exp_q.size(), 0);
        chk("done_single_pulse", prev_done, 1'b0);
        done_count++;
        done_cyc = cyc;
        resp_tile = 0; fp_seen = 0; dp_seen = 0;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc;

  task automatic run_job(input int mm, input int kk, input int nn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input int busy_start_at);
    int d0, exp_cc;
    bit got_done;
    build_model(mm, kk, nn, a, b, c);
    d0 = done_count;
    @(negedge clk);
    dim_m = 16'(mm); dim_k = 16'(kk); dim_n = 16'(nn);
    a_base = a; b_base = b; c_base = c;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    got_done = 0;
    for (int i = 0; i < 6000 && !got_done; i++) begin
      @(posedge clk);
      if (done_count != d0) got_done = 1;
      #1;
      if (busy_start_at > 0 && i == busy_start_at && !got_done) begin
        dim_m = 16'd3; dim_k = 16'd3; dim_n = 16'd3; a_base = 32'h5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      tests_run++; tests_failed++;
      $display("FAIL done_timeout: got no done within budget, expected done after %0d cycles", exp_cycles);
    end else begin
      chk("done_latency", done_cyc - start_cyc, exp_cycles);
    end
    @(negedge clk);
`ifdef GEMM_SEQ_CYCLE_CNT_EN
    exp_cc = exp_cycles;
`else
    exp_cc = 0;
`endif
    chk("idle_busy_after_done", busy, 1'b0);
    chk("done_low_after_pulse", done, 1'b0);
    chk("cycle_count", cycle_count, exp_cc);
    chk("leftover_ops", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int f0, ops0;
  bit found;

  initial begin
    rst = 1'b0; start = 1'b0;
    dim_m = '0; dim_k = '0; dim_n = '0;
    a_base = '0; b_base = '0; c_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bus_en", system_bus_en, 1'b0);
    chk("rst_rdwr", system_bus_rdwr, 1'b0);
    chk("rst_addr", system_bus_addr, 32'd0);
    chk("rst_wr_data", system_bus_wr_data, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_state", fsm_state, IDLE);
    rst = 1'b1;

    // Single tile, completion reported after two not-done polls.
    full_polls = {}; done_polls = 2;
    run_job(16, 16, 16, 32'd0, 32'd256, 32'd512, 0);
    chk("pin1_tiles", mdl_tiles, 1);
    chk("pin1_a", mdl_a[0], 32'd0);
    chk("pin1_b", mdl_b[0], 32'd496);
    chk("pin1_c", mdl_c[0], 32'd512);
    chk("pin1_ctrl", mdl_ctrl[0], 32'd3);
    chk("pin1_dim", mdl_dim[0], 32'd16912);

    // Four tiles with a ragged k and narrow n.
    full_polls = {0, 1, 0, 0}; done_polls = 0;
    run_job(20, 20, 5, 32'd0, 32'd1000, 32'd5000, 0);
    chk("pin2_tiles", mdl_tiles, 4);
    chk("pin2_ctrl0", mdl_ctrl[0], 32'd2);
    chk("pin2_ctrl1", mdl_ctrl[1], 32'd1);
    chk("pin2_ctrl2", mdl_ctrl[2], 32'd2);
    chk("pin2_ctrl3", mdl_ctrl[3], 32'd1);
    chk("pin2_a1", mdl_a[1], 32'd16);
    chk("pin2_b1", mdl_b[1], 32'd1095);
    chk("pin2_dim1", mdl_dim[1], 32'd5264);

    // Queue full for five polls: five extra +0 reads, nothing written meanwhile.
    full_polls = {5}; done_polls = 0;
    f0 = full_reads;
    run_job(16, 16, 16, 32'd100, 32'd200, 32'd300, 0);
    chk("full_hold_reads", full_reads - f0, 6);

    // Zero K: done on the following cycle, no bus traffic.
    full_polls = {}; done_polls = 0;
    ops0 = bus_ops;
    run_job(4, 0, 4, 32'd0, 32'd0, 32'd0, 0);
    chk("zero_dim_model_cycles", exp_cycles, 1);
    chk("zero_dim_no_bus", bus_ops - ops0, 0);

    // Multi-n walk, address wrap-around and a start pulse while busy.
    full_polls = {0, 2, 0, 1}; done_polls = 1;
    run_job(33, 17, 20, 32'hFFFF_FFF0, 32'h8000_0000, 32'hFFFF_FF00, 4);
    chk("pin3_tiles", mdl_tiles, 12);

    // Reset while writing the B tile address, then a clean re-run.
    full_polls = {}; done_polls = 0;
    build_model(16, 16, 16, 32'd0, 32'd256, 32'd512);
    @(negedge clk);
    dim_m = 16'd16; dim_k = 16'd16; dim_n = 16'd16;
    a_base = 32'd0; b_base = 32'd256; c_base = 32'd512;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (system_bus_en && system_bus_rdwr && system_bus_addr == BASE + 32'd4) found = 1;
    end
    chk("reset_hit_wr_badr", found, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_bus_en", system_bus_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_addr", system_bus_addr, 32'd0);
    chk("midrst_wr_data", system_bus_wr_data, 32'd0);
    chk("midrst_cycle_count", cycle_count, 32'd0);
    @(negedge clk);
    chk("midrst_state_idle", fsm_state, IDLE);
    chk("midrst_bus_en_next", system_bus_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_job(16, 16, 16, 32'd0, 32'd256, 32'd512, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have parameter GEMM_BASE, default 32'h9000_0000, the GEMM register block base address.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle job request; dim_m, dim_k, dim_n  in  16 each  matrix dimensions; a_base, b_base, c_base  in  32 each  element addresses.
REQ-004 SHALL have ports: busy  out  1  job active; done  out  1  one-cycle completion pulse; cycle_count  out  32  job cycle count.
REQ-005 SHALL have ports: system_bus_en  out  1; system_bus_rdwr  out  1 (1=write); system_bus_addr  out  32; system_bus_wr_data  out  32; system_bus_rd_data  in  32.

Function
REQ-006 SHALL latch dims and bases on start while in IDLE; start while busy is ignored.
REQ-007 SHALL walk tiles with n outermost (step SUPER_SYS_COLS), m middle (step 16), k innermost (step SUPER_SYS_ROWS).
REQ-008 SHALL set tile sizes nsz=min(COLS, N-n), msz=min(16, M-m), ksz=min(ROWS, K-k).
REQ-009 SHALL compute A_tile=a_base+m*K+k, B_tile=b_base+(k+ksz-1)*N+n, C_tile=c_base+m*N+n, all 32-bit modulo.
REQ-010 SHALL per tile issue one write per cycle in order: +12 <- K, +16 <- N, +0 <- A_tile, +4 <- B_tile, +8 <- C_tile, +20 <- {first,last}, +24 <- msz | ksz<<5 | nsz<<10.
REQ-011 SHALL set first=(k==0) and last=(k+ROWS>=K).
REQ-012 SHALL after the DIM write issue a read of +0 (POLL_FULL), sample system_bus_rd_data[0] the following cycle, re-issue the read while it is 1, advance when it is 0.
REQ-013 SHALL after the final tile poll +24 identically until rd_data[0]==1, then pulse done for one cycle and return to IDLE.
REQ-014 SHALL use states IDLE, WR_ASTR, WR_BSTR, WR_AADR, WR_BADR, WR_CADR, WR_CTRL, WR_DIM, POLL_FULL, ADVANCE, POLL_DONE, FINISH.
REQ-015 SHALL advance k; on k wrap reset k, advance m; on m wrap reset m, advance n; on n wrap go to POLL_DONE.
REQ-016 SHALL on start with any dimension zero pulse done the next cycle with no bus traffic.
REQ-017 SHALL hold system_bus_en low in IDLE, ADVANCE and FINISH; busy is high from the cycle after an accepted start through FINISH.

Reset
REQ-018 SHALL on rst low, at any time including mid-job, enter IDLE and force busy, done and system_bus_en to 0, system_bus_rdwr to 0, and addr, wr_data and tile counters to 0.
REQ-019 SHALL clear cycle_count on reset and on accepted start.

Configuration
REQ-020 SHALL, with GEMM_SEQ_CYCLE_CNT_EN defined, increment cycle_count every busy cycle and hold it after done.
REQ-021 SHALL, without GEMM_SEQ_CYCLE_CNT_EN, tie cycle_count to 0 and omit the counter logic.

Structure
REQ-022 SHALL take SUPER_SYS_ROWS and SUPER_SYS_COLS from Config, and add register offsets (A=0, B=4, C=8, ASTR=12, BSTR=16, CTRL=20, DIM=24), the M block size 16 and the state enum to Config.
REQ-023 SHALL place the k/m/n counters, size clamps and first/last logic in sub-module gemm_tile_walker; the FSM and bus drive stay in the top module.

Verification (ROWS=COLS=16)
REQ-024 SHALL check M=K=N=16 with bases 0/256/512: exactly one tile; A=0, B=496, C=512; CTRL=3; DIM=16|16<<5|16<<10; done after +24 reads 1.
REQ-025 SHALL check M=20, K=20, N=5: four tiles; CTRL sequence 2,1,2,1; second tile A=16, B=b_base+95, DIM=16|4<<5|5<<10.
REQ-026 SHALL check that full=1 held for 5 polls causes exactly 5 extra +0 reads and no write until full=0.
REQ-027 SHALL check start with dim_k=0: done the next cycle, system_bus_en never high.
REQ-028 SHALL check rst low during WR_BADR: the next cycle is IDLE with system_bus_en=0, and a new start re-runs from tile 0.
REQ-029 SHALL check, with GEMM_SEQ_CYCLE_CNT_EN defined, that cycle_count equals the number of busy cycles; without the macro it reads 0.
